// File: rtl/windowed_register_file.sv
// windowed_register_file: SPARC-style windowed integer register file with CWP/WIM window control
module windowed_register_file #(
    parameter int NWINDOWS = 4,
    parameter int CWPW     = 2
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic [4:0]          RA,
    input  logic [4:0]          RB,
    output logic [31:0]         QA,
    output logic [31:0]         QB,
    input  logic [4:0]          RW,
    input  logic [31:0]         D,
    input  logic                Le,
    input  logic                Save,
    input  logic                Restore,
    input  logic                WimLe,
    input  logic [NWINDOWS-1:0] WimD,
    output logic [CWPW-1:0]     CWP,
    output logic [NWINDOWS-1:0] WIM,
    output logic                Overflow,
    output logic                Underflow
);
    logic [31:0] glob [8];
    logic [31:0] locs [NWINDOWS][8];
    logic [31:0] ins  [NWINDOWS][8];
    logic [CWPW-1:0] cwp_m1, cwp_p1, cwp_nx;
    logic save_only, restore_only, ovf, unf;
    assign cwp_m1       = CWP - 1'b1;
    assign cwp_p1       = CWP + 1'b1;
    assign save_only    = Save & ~Restore;
    assign restore_only = Restore & ~Save;
    assign ovf          = save_only & WIM[cwp_m1];
    assign unf          = restore_only & WIM[cwp_p1];
    assign cwp_nx       = (save_only & ~ovf) ? cwp_m1 : (restore_only & ~unf) ? cwp_p1 : CWP;
    function automatic logic [31:0] rd(input logic [4:0] r);
        return r[4:3] == 2'd0 ? (r[2:0] == 3'd0 ? 32'd0 : glob[r[2:0]]) :
               r[4:3] == 2'd1 ? ins[cwp_m1][r[2:0]] :
               r[4:3] == 2'd2 ? locs[CWP][r[2:0]] : ins[CWP][r[2:0]];
    endfunction
    assign QA = rd(RA);
    assign QB = rd(RB);
    // window pointer, invalid mask and registered trap pulses
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            CWP       <= '0;
            WIM       <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            CWP       <= cwp_nx;
            Overflow  <= ovf;
            Underflow <= unf;
            if (WimLe) WIM <= WimD;
        end
    end
    // register storage; outs of window w are the ins bank of window w-1
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int e = 0; e < 8; e++) glob[e] <= '0;
            for (int w = 0; w < NWINDOWS; w++)
                for (int e = 0; e < 8; e++) begin
                    locs[w][e] <= '0;
                    ins[w][e]  <= '0;
                end
        end else if (Le) begin
            case (RW[4:3])
                2'd0: if (RW[2:0] != 3'd0) glob[RW[2:0]] <= D;
                2'd1: ins[cwp_m1][RW[2:0]] <= D;
                2'd2: locs[CWP][RW[2:0]] <= D;
                default: ins[CWP][RW[2:0]] <= D;
            endcase
        end
    end
endmodule
